// File: rtl/var_range_table_if.sv
// Bus between the clause loader / BCP readers and var_range_table:
// clear control, one write port and RD_PORTS packed read ports.
interface var_range_table_if #(
  parameter int VAR_BITS   = 6,
  parameter int RANGE_BITS = 10,
  parameter int RD_PORTS   = 2
);
  logic                           init_start;
  logic                           busy;
  logic                           wr_valid;
  logic                           wr_ready;
  logic [VAR_BITS-1:0]            wr_var;
  logic [RANGE_BITS-1:0]          wr_start;
  logic [RANGE_BITS-1:0]          wr_end;
  logic                           wr_err;
  logic [RD_PORTS-1:0]            rd_valid;
  logic [RD_PORTS*VAR_BITS-1:0]   rd_var;
  logic [RD_PORTS-1:0]            rd_resp_valid;
  logic [RD_PORTS*RANGE_BITS-1:0] rd_start;
  logic [RD_PORTS*RANGE_BITS-1:0] rd_end;
  logic [RD_PORTS-1:0]            rd_hit;
  logic [RD_PORTS-1:0]            rd_err;

  modport master (
    output init_start, wr_valid, wr_var, wr_start, wr_end, rd_valid, rd_var,
    input  busy, wr_ready, wr_err, rd_resp_valid, rd_start, rd_end, rd_hit, rd_err
  );

  modport slave (
    input  init_start, wr_valid, wr_var, wr_start, wr_end, rd_valid, rd_var,
    output busy, wr_ready, wr_err, rd_resp_valid, rd_start, rd_end, rd_hit, rd_err
  );
endinterface

// File: rtl/var_range_table.sv
// Variable -> {start, end} clause-range table with sequential clear FSM and RD_PORTS
// registered read ports. Define VAR_RANGE_BYPASS_EN for write-first same-cycle reads.
module var_range_table #(
  parameter int NUM_VARS   = 64,
  parameter int VAR_BITS   = 6,
  parameter int RANGE_BITS = 10,
  parameter int RD_PORTS   = 2
) (
  input logic              clock,
  input logic              reset,
  var_range_table_if.slave bus
);

  localparam int ADDR_BITS = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state, state_next;
  logic [VAR_BITS-1:0] clear_idx, clear_idx_next;

  logic [RANGE_BITS-1:0] start_mem [NUM_VARS];
  logic [RANGE_BITS-1:0] end_mem   [NUM_VARS];
  logic                  written   [NUM_VARS];

  logic wr_accept, wr_in_range;

  logic [VAR_BITS-1:0]   rd_idx   [RD_PORTS];
  logic                  rd_fire  [RD_PORTS];
  logic                  hit_d    [RD_PORTS];
  logic                  err_d    [RD_PORTS];
  logic [RANGE_BITS-1:0] start_d  [RD_PORTS];
  logic [RANGE_BITS-1:0] end_d    [RD_PORTS];

  function automatic logic in_range(input logic [VAR_BITS-1:0] idx);
    return int'(idx) < NUM_VARS;
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_of(input logic [VAR_BITS-1:0] idx);
    return idx[ADDR_BITS-1:0];
  endfunction

  assign wr_accept   = bus.wr_valid && bus.wr_ready;
  assign wr_in_range = in_range(bus.wr_var);

  always_comb begin
    state_next     = state;
    clear_idx_next = clear_idx;
    bus.busy       = 1'b0;
    bus.wr_ready   = 1'b0;
    unique case (state)
      CLEAR: begin
        bus.busy       = 1'b1;
        clear_idx_next = clear_idx + 1'b1;
        if (clear_idx == VAR_BITS'(NUM_VARS - 1)) state_next = IDLE;
      end
      IDLE: begin
        bus.wr_ready = !bus.init_start;
        if (bus.init_start) begin
          state_next     = CLEAR;
          clear_idx_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
    end else begin
      state     <= state_next;
      clear_idx <= clear_idx_next;
    end
  end

  // NOTE: the table arrays have no reset; the CLEAR sweep zeroes them, which keeps them RAM-mappable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        start_mem[addr_of(clear_idx)] <= '0;
        end_mem[addr_of(clear_idx)]   <= '0;
        written[addr_of(clear_idx)]   <= 1'b0;
      end else if (wr_accept && wr_in_range) begin
        start_mem[addr_of(bus.wr_var)] <= bus.wr_start;
        end_mem[addr_of(bus.wr_var)]   <= bus.wr_end;
        written[addr_of(bus.wr_var)]   <= 1'b1;
      end
    end
  end

  // Next read-response values per port; the table update lands at the same edge.
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_idx[p]  = bus.rd_var[p*VAR_BITS +: VAR_BITS];
      rd_fire[p] = bus.rd_valid[p] && (state == IDLE);
      hit_d[p]   = 1'b0;
      err_d[p]   = 1'b0;
      start_d[p] = '0;
      end_d[p]   = '0;
      if (!in_range(rd_idx[p])) begin
        err_d[p] = 1'b1;
`ifdef VAR_RANGE_BYPASS_EN
      end else if (wr_accept && wr_in_range && (bus.wr_var == rd_idx[p])) begin
        hit_d[p]   = 1'b1;
        start_d[p] = bus.wr_start;
        end_d[p]   = bus.wr_end;
`endif
      end else if (written[addr_of(rd_idx[p])]) begin
        hit_d[p]   = 1'b1;
        start_d[p] = start_mem[addr_of(rd_idx[p])];
        end_d[p]   = end_mem[addr_of(rd_idx[p])];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.rd_resp_valid <= '0;
      bus.rd_hit        <= '0;
      bus.rd_err        <= '0;
      bus.rd_start      <= '0;
      bus.rd_end        <= '0;
      bus.wr_err        <= 1'b0;
    end else begin
      bus.wr_err <= wr_accept && !wr_in_range;
      for (int p = 0; p < RD_PORTS; p++) begin
        bus.rd_resp_valid[p] <= rd_fire[p];
        if (rd_fire[p]) begin
          bus.rd_hit[p]                             <= hit_d[p];
          bus.rd_err[p]                             <= err_d[p];
          bus.rd_start[p*RANGE_BITS +: RANGE_BITS]  <= start_d[p];
          bus.rd_end[p*RANGE_BITS +: RANGE_BITS]    <= end_d[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_var_range_table.sv
// Directed bench for var_range_table: vector table for the single-cycle traffic plus
// hand sequences for reset/clear timing, init during write, and same-cycle bypass.
module tb_var_range_table;

  localparam int NV = 64;
  localparam int VB = 7;
  localparam int RB = 10;
  localparam int RP = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  var_range_table_if #(.VAR_BITS(VB), .RANGE_BITS(RB), .RD_PORTS(RP)) bus ();

  var_range_table #(.NUM_VARS(NV), .VAR_BITS(VB), .RANGE_BITS(RB), .RD_PORTS(RP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string         name;
    logic          wv;
    logic [VB-1:0] wvar;
    logic [RB-1:0] ws, we;
    logic [1:0]    rv;
    logic [VB-1:0] r0, r1;
    logic          werr;
    logic [1:0]    hit, err;
    logic [RB-1:0] s0, e0, s1, e1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.init_start = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_var     = '0;
    bus.wr_start   = '0;
    bus.wr_end     = '0;
    bus.rd_valid   = '0;
    bus.rd_var     = '0;
  endtask

  task automatic check_port(input string tag, input int p, input logic hit, input logic err,
                            input logic [RB-1:0] s, input logic [RB-1:0] e);
    check({tag, "_hit"},   32'(bus.rd_hit[p]), 32'(hit));
    check({tag, "_err"},   32'(bus.rd_err[p]), 32'(err));
    check({tag, "_start"}, 32'(bus.rd_start[p*RB +: RB]), 32'(s));
    check({tag, "_end"},   32'(bus.rd_end[p*RB +: RB]), 32'(e));
  endtask

  task automatic count_busy(input string tag, output int cnt, output logic bad_ready,
                            output logic bad_resp);
    cnt = 0;
    bad_ready = 1'b0;
    bad_resp = 1'b0;
    while (bus.busy && cnt < 1000) begin
      if (bus.wr_ready) bad_ready = 1'b1;
      step();
      cnt++;
      if (bus.rd_resp_valid != '0) bad_resp = 1'b1;
      if (!bus.busy) idle_inputs();
    end
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(NV));
  endtask

  int   cnt;
  logic bad_ready, bad_resp;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();

    // Reset state.
    check("rst_busy",       32'(bus.busy), 32'd1);
    check("rst_wr_ready",   32'(bus.wr_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.rd_resp_valid), 32'd0);
    check("rst_wr_err",     32'(bus.wr_err), 32'd0);
    check("rst_hit_err",    32'({bus.rd_hit, bus.rd_err}), 32'd0);
    check("rst_start_end",  32'(bus.rd_start | bus.rd_end), 32'd0);

    // Clear after reset, with writes, reads and init_start all ignored while busy.
    reset          = 1'b0;
    bus.rd_valid   = 2'b11;
    bus.rd_var     = {7'd2, 7'd1};
    bus.wr_valid   = 1'b1;
    bus.wr_var     = 7'd20;
    bus.wr_start   = 10'd5;
    bus.wr_end     = 10'd5;
    bus.init_start = 1'b1;
    count_busy("boot", cnt, bad_ready, bad_resp);
    check("boot_wr_ready_low", 32'(bad_ready), 32'd0);
    check("boot_resp_low",     32'(bad_resp), 32'd0);
    #1;
    check("idle_wr_ready", 32'(bus.wr_ready), 32'd1);

    //          name       wv wvar  ws     we    rv     r0     r1    werr hit    err    s0      e0    s1      e1
    vecs.push_back('{"wr5",     1, 7'd5,  10'd12, 10'd30, 2'b00, 7'd0,  7'd0,  0, 2'b00, 2'b00, 10'd0,    10'd0,  10'd0,    10'd0});
    vecs.push_back('{"rd5_6",   0, 7'd0,  10'd0,  10'd0,  2'b11, 7'd5,  7'd6,  0, 2'b01, 2'b00, 10'd12,   10'd30, 10'd0,    10'd0});
    vecs.push_back('{"wr63",    1, 7'd63, 10'd1023, 10'd7, 2'b00, 7'd0, 7'd0,  0, 2'b00, 2'b00, 10'd0,    10'd0,  10'd0,    10'd0});
    vecs.push_back('{"wr64",    1, 7'd64, 10'd55, 10'd66, 2'b00, 7'd0,  7'd0,  1, 2'b00, 2'b00, 10'd0,    10'd0,  10'd0,    10'd0});
    vecs.push_back('{"rd63_64", 0, 7'd0,  10'd0,  10'd0,  2'b11, 7'd63, 7'd64, 0, 2'b01, 2'b10, 10'd1023, 10'd7,  10'd0,    10'd0});
    vecs.push_back('{"wr9",     1, 7'd9,  10'd1,  10'd2,  2'b00, 7'd0,  7'd0,  0, 2'b00, 2'b00, 10'd0,    10'd0,  10'd0,    10'd0});
    vecs.push_back('{"rd9_p0",  0, 7'd0,  10'd0,  10'd0,  2'b01, 7'd9,  7'd0,  0, 2'b01, 2'b00, 10'd1,    10'd2,  10'd0,    10'd0});
    vecs.push_back('{"rd20_63", 0, 7'd0,  10'd0,  10'd0,  2'b11, 7'd20, 7'd63, 0, 2'b10, 2'b00, 10'd0,    10'd0,  10'd1023, 10'd7});
    vecs.push_back('{"wr6_rd5", 1, 7'd6,  10'd3,  10'd4,  2'b10, 7'd0,  7'd5,  0, 2'b10, 2'b00, 10'd0,    10'd0,  10'd12,   10'd30});
    vecs.push_back('{"rd6_p0",  0, 7'd0,  10'd0,  10'd0,  2'b01, 7'd6,  7'd0,  0, 2'b01, 2'b00, 10'd3,    10'd4,  10'd0,    10'd0});
    vecs.push_back('{"rd64_64", 0, 7'd0,  10'd0,  10'd0,  2'b11, 7'd64, 7'd64, 0, 2'b00, 2'b11, 10'd0,    10'd0,  10'd0,    10'd0});
    vecs.push_back('{"nop",     0, 7'd0,  10'd0,  10'd0,  2'b00, 7'd0,  7'd0,  0, 2'b00, 2'b00, 10'd0,    10'd0,  10'd0,    10'd0});

    foreach (vecs[i]) begin
      bus.wr_valid = vecs[i].wv;
      bus.wr_var   = vecs[i].wvar;
      bus.wr_start = vecs[i].ws;
      bus.wr_end   = vecs[i].we;
      bus.rd_valid = vecs[i].rv;
      bus.rd_var   = {vecs[i].r1, vecs[i].r0};
      step();
      idle_inputs();
      check({vecs[i].name, "_resp_valid"}, 32'(bus.rd_resp_valid), 32'(vecs[i].rv));
      check({vecs[i].name, "_wr_err"},     32'(bus.wr_err), 32'(vecs[i].werr));
      if (vecs[i].rv[0])
        check_port({vecs[i].name, "_p0"}, 0, vecs[i].hit[0], vecs[i].err[0], vecs[i].s0, vecs[i].e0);
      if (vecs[i].rv[1])
        check_port({vecs[i].name, "_p1"}, 1, vecs[i].hit[1], vecs[i].err[1], vecs[i].s1, vecs[i].e1);
    end

    // Same-cycle write and read of var 9 (currently {1, 2}).
    bus.wr_valid = 1'b1;
    bus.wr_var   = 7'd9;
    bus.wr_start = 10'd100;
    bus.wr_end   = 10'd120;
    bus.rd_valid = 2'b11;
    bus.rd_var   = {7'd9, 7'd9};
    step();
    idle_inputs();
    check("same9_resp_valid", 32'(bus.rd_resp_valid), 32'd3);
`ifdef VAR_RANGE_BYPASS_EN
    check_port("same9_p0", 0, 1'b1, 1'b0, 10'd100, 10'd120);
    check_port("same9_p1", 1, 1'b1, 1'b0, 10'd100, 10'd120);
`else
    check_port("same9_p0", 0, 1'b1, 1'b0, 10'd1, 10'd2);
    check_port("same9_p1", 1, 1'b1, 1'b0, 10'd1, 10'd2);
`endif
    bus.rd_valid = 2'b11;
    bus.rd_var   = {7'd9, 7'd9};
    step();
    idle_inputs();
    check_port("after9_p0", 0, 1'b1, 1'b0, 10'd100, 10'd120);
    check_port("after9_p1", 1, 1'b1, 1'b0, 10'd100, 10'd120);

    // Same-cycle write and read of never-written var 30.
    bus.wr_valid = 1'b1;
    bus.wr_var   = 7'd30;
    bus.wr_start = 10'd77;
    bus.wr_end   = 10'd88;
    bus.rd_valid = 2'b01;
    bus.rd_var   = {7'd0, 7'd30};
    step();
    idle_inputs();
`ifdef VAR_RANGE_BYPASS_EN
    check_port("same30_p0", 0, 1'b1, 1'b0, 10'd77, 10'd88);
`else
    check_port("same30_p0", 0, 1'b0, 1'b0, 10'd0, 10'd0);
`endif

    // Populate vars 0..3, then init_start with a concurrent write.
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_var   = VB'(i);
      bus.wr_start = RB'(40 + i);
      bus.wr_end   = RB'(50 + i);
      step();
    end
    idle_inputs();
    bus.rd_valid = 2'b11;
    bus.rd_var   = {7'd0, 7'd3};
    step();
    idle_inputs();
    check_port("pop_p0", 0, 1'b1, 1'b0, 10'd43, 10'd53);
    check_port("pop_p1", 1, 1'b1, 1'b0, 10'd40, 10'd50);

    bus.init_start = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_var     = 7'd2;
    bus.wr_start   = 10'd999;
    bus.wr_end     = 10'd999;
    #1;
    check("init_wr_ready", 32'(bus.wr_ready), 32'd0);
    step();
    idle_inputs();
    count_busy("init", cnt, bad_ready, bad_resp);
    check("init_wr_ready_low", 32'(bad_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.rd_valid = 2'b11;
      bus.rd_var   = {VB'(i), VB'(i)};
      step();
      idle_inputs();
      check($sformatf("cleared%0d_valid", i), 32'(bus.rd_resp_valid), 32'd3);
      check_port($sformatf("cleared%0d_p0", i), 0, 1'b0, 1'b0, 10'd0, 10'd0);
      check_port($sformatf("cleared%0d_p1", i), 1, 1'b0, 1'b0, 10'd0, 10'd0);
    end

    // Reset 20 cycles into a clear restarts it from index 0.
    bus.init_start = 1'b1;
    step();
    idle_inputs();
    repeat (19) step();
    check("midclear_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    repeat (2) step();
    check("midrst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    count_busy("midrst", cnt, bad_ready, bad_resp);
    check("midrst_wr_ready_low", 32'(bad_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/var_range_table.md
Name: var_range_table

Overview:
- Parametrised, multi-port successor of the variable-to-clause-range lookup table in the SAT engine.
- Stores a {start, end} clause-table index pair per variable, with a per-entry written flag.
- Has one write port with a ready handshake and RD_PORTS independent registered read ports.
- Includes an FSM that sequentially clears all entries; it sits between the clause loader (writer) and the BCP/implication units (readers).

Parameters:
- NUM_VARS, 64, number of table entries (variables).
- VAR_BITS, 6, width of a variable index; must satisfy 2^VAR_BITS >= NUM_VARS.
- RANGE_BITS, 10, width of each start/end clause-table index.
- RD_PORTS, 2, number of independent read ports.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- init_start  in  1  request a full table clear (accepted only in IDLE)
- busy  out  1  high while clearing
- wr_valid  in  1  write request
- wr_ready  out  1  write can be accepted this cycle
- wr_var  in  VAR_BITS  write index
- wr_start  in  RANGE_BITS  clause range start
- wr_end  in  RANGE_BITS  clause range end
- wr_err  out  1  one-cycle pulse: accepted write had an out-of-range index
- rd_valid  in  RD_PORTS  per-port read request
- rd_var  in  RD_PORTS*VAR_BITS  per-port index; port p uses bits [p*VAR_BITS +: VAR_BITS]
- rd_resp_valid  out  RD_PORTS  per-port response valid
- rd_start  out  RD_PORTS*RANGE_BITS  per-port start
- rd_end  out  RD_PORTS*RANGE_BITS  per-port end
- rd_hit  out  RD_PORTS  entry has been written since the last clear
- rd_err  out  RD_PORTS  requested index >= NUM_VARS

Behaviour:
- States: CLEAR and IDLE.
- Reset:
  - Enters CLEAR with clear_idx=0.
  - All outputs are 0 except busy=1.
  - Reset asserted mid-CLEAR restarts the clear at index 0.
- CLEAR:
  - Each cycle zeroes entry clear_idx (start, end and written flag), then increments clear_idx.
  - After clearing index NUM_VARS-1, moves to IDLE on the next edge; the clear takes exactly NUM_VARS cycles.
  - In CLEAR: busy=1, wr_ready=0.
  - Read requests are ignored: rd_resp_valid=0 one cycle later.
  - init_start is ignored.
- IDLE:
  - busy=0.
  - wr_ready = !init_start.
  - init_start=1 moves to CLEAR next cycle with clear_idx=0; a same-cycle write is not accepted (wr_ready=0).
- Write accept:
  - Occurs when wr_valid && wr_ready.
  - If wr_var < NUM_VARS, the entry is updated and written=1 at the edge.
  - Otherwise the table is unchanged and wr_err=1 in the following cycle.
  - No ordering check between start and end; values are stored verbatim.
- Read:
  - Fixed 1-cycle latency.
  - rd_valid[p] at cycle N (in IDLE) gives rd_resp_valid[p]=1 at N+1 with registered outputs; outputs hold their last value when rd_resp_valid=0.
  - If the index is out of range: rd_err=1, rd_hit=0, start=end=0.
  - Unwritten entry: rd_hit=0, start=end=0.
  - Ports are fully independent; identical indices on multiple ports all return the same data.
- Read/write same index, same cycle: see Optional Feature.
- Write then read, different cycles: the read returns the new data.

Optional Feature:
- Macro: VAR_RANGE_BYPASS_EN.
- Defined: a read and an accepted in-range write to the same index in the same cycle return the newly written start/end with rd_hit=1 (write-first).
- Undefined: that read returns the pre-write contents (read-first), including rd_hit=0 if the entry was never written.
- Table contents after the cycle are identical in both builds.

Test Plan:
- Reset, then count busy cycles -> busy high exactly 64 cycles, wr_ready=0 throughout, rd_valid during CLEAR yields rd_resp_valid=0.
- Write var 5 = {start 12, end 30}, then read port 0 var 5 and port 1 var 6 -> port 0: hit=1, 12/30; port 1: hit=0, 0/0; both valid one cycle after request.
- Write var 63 and var 64 -> var 63 reads back correctly; var 64 gives wr_err pulse, and a read of var 64 gives rd_err=1, hit=0.
- Same-cycle write var 9 = {100, 120} and read var 9 on both ports, after var 9 = {1, 2} earlier -> bypass build returns 100/120, non-bypass build returns 1/2; both builds read 100/120 the next cycle.
- Populate vars 0..3, assert init_start together with wr_valid -> write rejected, busy for 64 cycles, then all reads give hit=0.
- Assert reset at clear cycle 20 -> clear restarts and busy stays high 64 cycles after reset deasserts.
